// File: rtl/rob_retire_if.sv
// Signal bundle between the ROB-head retirement controller and the ROB, R-RAT, RAT and freelist.
// The master modport is the controller's view. The slave modport is the view of the surrounding structures.
interface rob_retire_if #(
  parameter int NUM_ARCH_REGS = 32,
  parameter int NUM_PHYS_REGS = 64
);
  localparam int LOG_ARCH = $clog2(NUM_ARCH_REGS);
  localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS);

  // ROB head
  logic                head_valid;
  logic                head_done;
  logic                head_has_dest;
  logic [LOG_ARCH-1:0] head_arch;
  logic [LOG_PHYS-1:0] head_phys;
  logic [LOG_PHYS-1:0] head_prev;
  logic                head_flush;
  logic                pop;

  // Commit side: R-RAT write and freelist return
  logic                rrat_we;
  logic [LOG_ARCH-1:0] rrat_arch;
  logic [LOG_PHYS-1:0] rrat_phys;
  logic                free_valid;
  logic [LOG_PHYS-1:0] free_phys;

  // Recovery side: flush, R-RAT read and front-end RAT restore
  logic                flush;
  logic [LOG_ARCH-1:0] rrat_rd_idx;
  logic [LOG_PHYS-1:0] rrat_rd_data;
  logic                rat_we;
  logic [LOG_ARCH-1:0] rat_arch;
  logic [LOG_PHYS-1:0] rat_phys;
  logic                stall;
  logic [31:0]         retired_cnt;

  modport master (
    input  head_valid, head_done, head_has_dest, head_arch, head_phys, head_prev, head_flush,
    input  rrat_rd_data,
    output pop, rrat_we, rrat_arch, rrat_phys, free_valid, free_phys,
    output flush, rrat_rd_idx, rat_we, rat_arch, rat_phys, stall, retired_cnt
  );

  modport slave (
    output head_valid, head_done, head_has_dest, head_arch, head_phys, head_prev, head_flush,
    output rrat_rd_data,
    input  pop, rrat_we, rrat_arch, rrat_phys, free_valid, free_phys,
    input  flush, rrat_rd_idx, rat_we, rat_arch, rat_phys, stall, retired_cnt
  );
endinterface

// File: rtl/rob_retire_ctrl.sv
// In-order ROB-head retirement controller. It commits at most one head entry per cycle.
// On a committed mispredict or exception it flushes, then copies the R-RAT into the RAT one register per cycle.
module rob_retire_ctrl #(
  parameter int NUM_ARCH_REGS = 32,
  parameter int NUM_PHYS_REGS = 64
) (
  input  logic CLK,
  input  logic RESET,
  rob_retire_if.master bus
);
  localparam int LOG_ARCH = $clog2(NUM_ARCH_REGS);
  localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS);
  localparam logic [LOG_ARCH-1:0] IDX_LAST = LOG_ARCH'(NUM_ARCH_REGS - 1);

  typedef enum logic [1:0] {RUN, FLUSH, RESTORE} state_t;
  typedef logic [LOG_PHYS-1:0] phys_t;

  state_t              state, state_nxt;
  logic [LOG_ARCH-1:0] idx, idx_nxt;
  logic                flush_pend, flush_pend_nxt;
  logic [31:0]         retired_cnt;
  logic                commit;
  phys_t               restore_data;

  assign commit       = (state == RUN) && bus.head_valid && bus.head_done && !flush_pend;
  assign restore_data = bus.rrat_rd_data;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= RUN;
      idx         <= '0;
      flush_pend  <= 1'b0;
      retired_cnt <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      flush_pend <= flush_pend_nxt;
      if (commit) retired_cnt <= retired_cnt + 32'd1;
    end
  end

  // NOTE: each combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    flush_pend_nxt = flush_pend;
    unique case (state)
      RUN: begin
        idx_nxt = '0;
        if (commit && bus.head_flush) begin
          state_nxt      = FLUSH;
          flush_pend_nxt = 1'b1;
        end
      end
      FLUSH: begin
        state_nxt      = RESTORE;
        idx_nxt        = '0;
        flush_pend_nxt = 1'b0;
      end
      RESTORE: begin
        if (idx == IDX_LAST) begin
          state_nxt = RUN;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: begin
        state_nxt      = RUN;
        idx_nxt        = '0;
        flush_pend_nxt = 1'b0;
      end
    endcase
  end

  // Reset masks every output combinationally. An asserted reset therefore silences the interface at once, not at the next edge.
  always_comb begin
    bus.pop         = 1'b0;
    bus.rrat_we     = 1'b0;
    bus.rrat_arch   = '0;
    bus.rrat_phys   = '0;
    bus.free_valid  = 1'b0;
    bus.free_phys   = '0;
    bus.flush       = 1'b0;
    bus.rrat_rd_idx = '0;
    bus.rat_we      = 1'b0;
    bus.rat_arch    = '0;
    bus.rat_phys    = '0;
    bus.stall       = 1'b0;
    bus.retired_cnt = '0;
    if (RESET) begin
      bus.pop         = commit;
      bus.rrat_we     = commit && bus.head_has_dest;
      bus.rrat_arch   = bus.head_arch;
      bus.rrat_phys   = bus.head_phys;
      bus.free_valid  = commit && bus.head_has_dest;
      bus.free_phys   = bus.head_prev;
      bus.flush       = (state == FLUSH);
      bus.rrat_rd_idx = idx;
      bus.rat_we      = (state == RESTORE);
      bus.rat_arch    = idx;
      bus.rat_phys    = restore_data;
      bus.stall       = (state != RUN) || (commit && bus.head_flush);
      bus.retired_cnt = retired_cnt;
    end
  end
endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Directed bench for rob_retire_ctrl. An R-RAT model with combinational read answers restore reads.
// Expected values are hand-computed per vector.
module tb_rob_retire_ctrl;
  localparam int NA = 32;
  localparam int NP = 64;
  localparam int LA = 5;
  localparam int LP = 6;

  logic CLK = 1'b0;
  logic RESET;

  rob_retire_if #(.NUM_ARCH_REGS(NA), .NUM_PHYS_REGS(NP)) bus ();

  rob_retire_ctrl #(.NUM_ARCH_REGS(NA), .NUM_PHYS_REGS(NP)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // R-RAT: loaded with identity mapping on the first edge, then written by commits
  logic [LP-1:0] rrat [NA];
  bit            rrat_loaded = 1'b0;
  always @(posedge CLK) begin
    if (!rrat_loaded) begin
      for (int i = 0; i < NA; i++) rrat[i] <= LP'(i);
      rrat_loaded <= 1'b1;
    end else if (bus.rrat_we) begin
      rrat[bus.rrat_arch] <= bus.rrat_phys;
    end
  end
  assign bus.rrat_rd_data = rrat[bus.rrat_rd_idx];

  int checks = 0;
  int passes = 0;
  int exp_rat [NA];

  int   v3_arch [4] = '{1, 2, 4, 6};
  int   v3_phys [4] = '{42, 43, 44, 45};
  int   v3_prev [4] = '{20, 21, 22, 23};
  logic v3_dest [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_en(input string tag, input logic p, input logic w, input logic f);
    check({tag, ".pop"},     32'(bus.pop),        32'(p));
    check({tag, ".rrat_we"}, 32'(bus.rrat_we),    32'(w));
    check({tag, ".free"},    32'(bus.free_valid), 32'(f));
  endtask

  task automatic set_head(input logic v, input logic d, input logic hd, input int a, input int p,
                          input int pv, input logic fl);
    bus.head_valid    = v;
    bus.head_done     = d;
    bus.head_has_dest = hd;
    bus.head_arch     = LA'(a);
    bus.head_phys     = LP'(p);
    bus.head_prev     = LP'(pv);
    bus.head_flush    = fl;
  endtask

  task automatic to_neg();
    @(negedge CLK);
  endtask

  task automatic to_pos();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NA; i++) exp_rat[i] = i;

    // Reset: a valid, done head must not leak through
    RESET = 1'b0;
    set_head(1, 1, 1, 5, 40, 7, 1);
    #2;
    chk_en("reset", 0, 0, 0);
    check("reset.flush",     32'(bus.flush),     0);
    check("reset.stall",     32'(bus.stall),     0);
    check("reset.rat_we",    32'(bus.rat_we),    0);
    check("reset.rrat_arch", 32'(bus.rrat_arch), 0);
    check("reset.cnt",       bus.retired_cnt,    0);
    set_head(0, 0, 0, 0, 0, 0, 0);
    to_neg();
    RESET = 1'b1;
    to_pos();

    // 1: single commit with destination
    set_head(1, 1, 1, 5, 40, 7, 0);
    to_neg();
    chk_en("t1", 1, 1, 1);
    check("t1.rrat_arch", 32'(bus.rrat_arch), 5);
    check("t1.rrat_phys", 32'(bus.rrat_phys), 40);
    check("t1.free_phys", 32'(bus.free_phys), 7);
    check("t1.stall",     32'(bus.stall),     0);
    check("t1.cnt0",      bus.retired_cnt,    0);
    to_pos();
    exp_rat[5] = 40;
    set_head(0, 0, 0, 0, 0, 0, 0);
    check("t1.cnt1", bus.retired_cnt, 1);

    // 2: head valid but not done for 10 cycles
    set_head(1, 0, 1, 9, 41, 12, 0);
    for (int c = 0; c < 10; c++) begin
      to_neg();
      chk_en("t2.wait", 0, 0, 0);
      to_pos();
    end
    bus.head_done = 1'b1;
    to_neg();
    chk_en("t2.go", 1, 1, 1);
    check("t2.free_phys", 32'(bus.free_phys), 12);
    to_pos();
    exp_rat[9] = 41;
    set_head(0, 0, 0, 0, 0, 0, 0);
    check("t2.cnt", bus.retired_cnt, 2);

    // 3: four back-to-back commits, second without destination
    for (int k = 0; k < 4; k++) begin
      set_head(1, 1, v3_dest[k], v3_arch[k], v3_phys[k], v3_prev[k], 0);
      to_neg();
      chk_en("t3", 1, v3_dest[k], v3_dest[k]);
      check("t3.free_phys", 32'(bus.free_phys), 32'(v3_prev[k]));
      to_pos();
    end
    set_head(0, 0, 0, 0, 0, 0, 0);
    exp_rat[1] = 42;
    exp_rat[4] = 44;
    exp_rat[6] = 45;
    check("t3.cnt", bus.retired_cnt, 6);

    // 4: flush-committing head, then FLUSH, then a full RESTORE
    set_head(1, 1, 1, 3, 50, 13, 1);
    to_neg();
    chk_en("t4.commit", 1, 1, 1);
    check("t4.commit.stall", 32'(bus.stall), 1);
    check("t4.commit.flush", 32'(bus.flush), 0);
    to_pos();
    exp_rat[3] = 50;
    set_head(1, 1, 0, 0, 60, 14, 0);
    to_neg();
    chk_en("t4.flush", 0, 0, 0);
    check("t4.flush.flush",  32'(bus.flush),  1);
    check("t4.flush.stall",  32'(bus.stall),  1);
    check("t4.flush.rat_we", 32'(bus.rat_we), 0);
    to_pos();
    check("t4.cnt_flush", bus.retired_cnt, 7);
    for (int i = 0; i < NA; i++) begin
      to_neg();
      check("t4.rest.rat_we",   32'(bus.rat_we),   1);
      check("t4.rest.rat_arch", 32'(bus.rat_arch), 32'(i));
      check("t4.rest.rat_phys", 32'(bus.rat_phys), 32'(exp_rat[i]));
      check("t4.rest.stall",    32'(bus.stall),    1);
      check("t4.rest.pop",      32'(bus.pop),      0);
      check("t4.rest.flush",    32'(bus.flush),    0);
      to_pos();
    end
    to_neg();
    check("t4.run.pop",    32'(bus.pop),    1);
    check("t4.run.stall",  32'(bus.stall),  0);
    check("t4.run.rat_we", 32'(bus.rat_we), 0);
    to_pos();
    check("t4.cnt_run", bus.retired_cnt, 8);

    // 5: reset asserted in the middle of RESTORE
    set_head(1, 1, 0, 0, 61, 15, 1);
    to_neg();
    check("t5.commit.stall", 32'(bus.stall), 1);
    to_pos();
    set_head(1, 1, 0, 0, 61, 15, 0);
    to_pos();
    repeat (10) to_pos();
    to_neg();
    check("t5.idx10.rat_arch", 32'(bus.rat_arch), 10);
    check("t5.idx10.rat_we",   32'(bus.rat_we),   1);
    #1 RESET = 1'b0;
    #1;
    check("t5.rst.rat_we",   32'(bus.rat_we),   0);
    check("t5.rst.stall",    32'(bus.stall),    0);
    check("t5.rst.pop",      32'(bus.pop),      0);
    check("t5.rst.rat_arch", 32'(bus.rat_arch), 0);
    check("t5.rst.cnt",      bus.retired_cnt,   0);
    to_pos();
    check("t5.rst.cnt_hold", bus.retired_cnt, 0);
    to_neg();
    RESET = 1'b1;
    #1;
    check("t5.run.pop",    32'(bus.pop),    1);
    check("t5.run.stall",  32'(bus.stall),  0);
    check("t5.run.rat_we", 32'(bus.rat_we), 0);
    check("t5.run.flush",  32'(bus.flush),  0);
    to_pos();
    set_head(0, 0, 0, 0, 0, 0, 0);
    check("t5.cnt", bus.retired_cnt, 1);

    // 6: counter wrap
    to_neg();
    force dut.retired_cnt = 32'hFFFF_FFFF;
    #1 release dut.retired_cnt;
    check("t6.cnt_max", bus.retired_cnt, 32'hFFFF_FFFF);
    set_head(1, 1, 0, 0, 62, 16, 0);
    to_pos();
    set_head(0, 0, 0, 0, 0, 0, 0);
    check("t6.cnt_wrap", bus.retired_cnt, 0);
    to_pos();
    check("t6.cnt_idle", bus.retired_cnt, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
